// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, programmable wait states, byte-lane store or aligned load, valid/ready response out.
// Optional build macro DMEM_B2B_EN: a new request may be accepted in the same cycle the current response is taken.
module dmem_responder #(
    parameter int AWIDTH      = 10,
    parameter int DWIDTH      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam int CW     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int NWORDS = 2 ** (AWIDTH - 2);

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              accept;
    logic              acc_fire;
    logic              acc_from_req;
    logic              acc_we;
    logic [1:0]        acc_size;
    logic [31:0]       acc_addr;
    logic [DWIDTH-1:0] acc_wdata;
    logic              acc_err;
    logic [3:0]        acc_be;
    logic [DWIDTH-1:0] acc_lanes;
    logic [AWIDTH-3:0] acc_widx;
    logic [DWIDTH-1:0] rd_word;

    always_comb begin
        req_ready = (state_q == ST_IDLE);
`ifdef DMEM_B2B_EN
        if (state_q == ST_RESP) begin
            req_ready = rsp_ready;
        end
`endif
    end

    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // With zero wait states the access uses the live request on its acceptance edge.
    assign acc_from_req = (state_q != ST_WAIT);
    assign acc_we       = acc_from_req ? req_we    : we_q;
    assign acc_size     = acc_from_req ? req_size  : size_q;
    assign acc_addr     = acc_from_req ? req_addr  : addr_q;
    assign acc_wdata    = acc_from_req ? req_wdata : wdata_q;
    assign acc_widx     = acc_addr[AWIDTH-1:2];
    assign acc_fire     = (WAIT_CYCLES == 0) ? accept
                                             : ((state_q == ST_WAIT) && (cnt_q == '0));

    always_comb begin
        acc_err   = (acc_addr[31:AWIDTH] != '0);
        acc_be    = 4'b0000;
        acc_lanes = acc_wdata;
        case (acc_size)
            2'b00: begin
                acc_be    = 4'b0001 << acc_addr[1:0];
                acc_lanes = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                acc_be    = acc_addr[1] ? 4'b1100 : 4'b0011;
                acc_lanes = {2{acc_wdata[15:0]}};
                if (acc_addr[0]) acc_err = 1'b1;
            end
            2'b10: begin
                acc_be = 4'b1111;
                if (acc_addr[1:0] != 2'b00) acc_err = 1'b1;
            end
            default: acc_err = 1'b1;
        endcase
    end

    // One byte-wide array per lane so each lane maps onto its own write enable.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [NWORDS];

            always_ff @(posedge clk) begin
                if (acc_fire && acc_we && !acc_err && acc_be[gi]) begin
                    lane_mem[acc_widx] <= acc_lanes[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = lane_mem[acc_widx];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CW'(WAIT_CYCLES - 1);
                    end
                end else if ((state_q == ST_RESP) && rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (acc_fire) begin
            err_d   = acc_err;
            rdata_d = (acc_we || acc_err) ? '0 : rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule
